scan_sequencer: RTL

Frame-level controller sitting directly upstream of the Transmitter. It sweeps the steering angle from a start to a stop value in fixed steps. For each scanline it presents stable `r_0`, `angle` and `num_points`, pulses `initiate`, waits for the Transmitter's `done`, and then inserts a programmable listen gap before moving to the next line. It reports per-line progress and end of frame to the system controller.

---
 rtl/scan_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/scan_sequencer.sv
// Frame sequencer upstream of the Transmitter: sweeps angle start..stop by step, one scanline at a time.
// Optional SEQ_CONTINUOUS_EN: restart the sweep after each frame instead of returning to IDLE.
module scan_sequencer #(
  parameter int DW_ANGLE  = 8,
  parameter int DW_INPUT  = 8,
  parameter int DW_POINTS = 13,
  parameter int DW_GAP    = 16,
  parameter int SETUP_CYC = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DW_INPUT-1:0]  cfg_r_0,
  input  logic [DW_ANGLE-1:0]  cfg_angle_start,
  input  logic [DW_ANGLE-1:0]  cfg_angle_stop,
  input  logic [DW_ANGLE-1:0]  cfg_angle_step,
  input  logic [DW_POINTS-1:0] cfg_num_points,
  input  logic [DW_GAP-1:0]    cfg_gap,
  output logic [DW_INPUT-1:0]  r_0,
  output logic [DW_ANGLE-1:0]  angle,
  output logic [DW_POINTS-1:0] num_points,
  output logic                 initiate,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [7:0]           line_idx,
  output logic                 frame_done,
  output logic                 cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FIRE, S_WAIT_DONE, S_GAP, S_NEXT, S_DRAIN
  } state_t;

  localparam logic [DW_GAP-1:0] SETUP_LAST = DW_GAP'(SETUP_CYC - 1);

  state_t state, state_nxt;

  logic [DW_ANGLE-1:0] start_q, stop_q, step_q;
  logic [DW_GAP-1:0]   gap_q, cnt;
  logic [DW_ANGLE:0]   angle_sum;
  logic                cfg_ok, sweep_end;
  logic                load_frame, advance, rewind, err_set;

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt  = state;
    initiate   = 1'b0;
    frame_done = 1'b0;
    load_frame = 1'b0;
    advance    = 1'b0;
    rewind     = 1'b0;
    err_set    = 1'b0;
    cfg_ok     = (cfg_angle_step != '0) && (cfg_angle_start <= cfg_angle_stop);
    // One extra bit so a wrap past the top of the angle range ends the sweep.
    angle_sum  = {1'b0, angle} + {1'b0, step_q};
    sweep_end  = (angle_sum > {1'b0, stop_q});

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          if (cfg_ok) begin
            load_frame = 1'b1;
            state_nxt  = S_SETUP;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (abort)                   state_nxt = S_IDLE;
        else if (cnt == SETUP_LAST)  state_nxt = S_FIRE;
      end
      S_FIRE: begin
        initiate  = 1'b1;
        state_nxt = abort ? S_DRAIN : S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
          if (abort)              state_nxt = S_IDLE;
          else if (gap_q != '0)   state_nxt = S_GAP;
          else                    state_nxt = S_NEXT;
        end else if (abort) begin
          state_nxt = S_DRAIN;
        end
      end
      S_GAP: begin
        if (abort)                              state_nxt = S_IDLE;
        else if (cnt == gap_q - DW_GAP'(1))     state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (sweep_end) begin
          frame_done = 1'b1;
`ifdef SEQ_CONTINUOUS_EN
          rewind     = 1'b1;
          state_nxt  = S_SETUP;
`else
          state_nxt  = S_IDLE;
`endif
        end else begin
          advance   = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_DRAIN: begin
        if (tx_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      gap_q      <= '0;
      r_0        <= '0;
      angle      <= '0;
      num_points <= '0;
      line_idx   <= '0;
      cfg_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= (state_nxt != state) ? '0 : cnt + DW_GAP'(1);
      cfg_err <= err_set;
      if (load_frame) begin
        start_q    <= cfg_angle_start;
        stop_q     <= cfg_angle_stop;
        step_q     <= cfg_angle_step;
        gap_q      <= cfg_gap;
        r_0        <= cfg_r_0;
        angle      <= cfg_angle_start;
        num_points <= cfg_num_points;
        line_idx   <= '0;
      end
      if (advance) begin
        angle    <= angle_sum[DW_ANGLE-1:0];
        line_idx <= line_idx + 8'd1;
      end
      if (rewind) begin
        angle    <= start_q;
        line_idx <= '0;
      end
    end
  end

endmodule
